// File: rtl/lc3b_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// lc3b_ctrl_sequencer
//
// Multi-cycle control sequencer for the LC-3b datapath. One decoded
// instruction is accepted at a time, then stepped through EXEC, optional
// memory phases (MEM1, MEM2 for indirect access) and an optional writeback
// phase. Memory phases wait on a variable-latency mem_resp and abort after
// MAX_MEM_WAIT cycles without a response.
//
// Handshake: an instruction transfers on any rising edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE while flush is
// low. The opcode and mode bits are captured on that edge, and the
// instruction is executed from the captured copy.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake
//   opcode              4-bit LC-3b opcode
//   imm_bit             IR[5]  ADD/AND immediate select, SHF arithmetic select
//   shf_dir             IR[4]  0 shift left, 1 shift right
//   jsr_bit             IR[11] 1 JSR (PC-relative), 0 JSRR (register)
//   flush               abandon the current instruction, return to IDLE
//   mem_resp            memory access complete this cycle
//   aluop               ALU operation (add/and/not/pass/sll/srl/sra)
//   *_sel               datapath mux selects
//   mem_read/mem_write  memory request
//   load_*              register load strobes
//   busy                sequencer not in IDLE
//   illegal_op          one-cycle pulse after an illegal opcode's EXEC
//   mem_error           one-cycle pulse after a memory timeout
//   fsm_state           current FSM state, for observation
// ---------------------------------------------------------------------------
module lc3b_ctrl_sequencer #(
  parameter int unsigned MAX_MEM_WAIT    = 15,
  parameter bit          ENABLE_INDIRECT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] opcode,
  input  logic       imm_bit,
  input  logic       shf_dir,
  input  logic       jsr_bit,
  input  logic       flush,
  input  logic       mem_resp,
  output logic [2:0] aluop,
  output logic       sr2mux_sel,
  output logic       addr1mux_sel,
  output logic       memaddrmux_sel,
  output logic       destmux_sel,
  output logic       jsrmux_sel,
  output logic [1:0] addr2mux_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       load_regfile,
  output logic       load_cc,
  output logic       load_pc,
  output logic       load_mar_indirect,
  output logic       busy,
  output logic       illegal_op,
  output logic       mem_error,
  output logic [2:0] fsm_state
);

  // FSM states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MEM1 = 3'd2;
  localparam logic [2:0] S_MEM2 = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  // LC-3b opcodes
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;
  localparam logic [2:0] ALU_SLL  = 3'd4;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] ALU_SRA  = 3'd6;

  // Wait-counter value reached in the last allowed cycle of a request.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [7:0] wait_cnt;
  logic [3:0] op_q;
  logic       imm_q;
  logic       shf_q;
  logic       jsr_q;

  logic handshake;
  logic is_load_direct;
  logic is_store_direct;
  logic is_indirect;
  logic is_illegal;
  logic mem_active;
  logic wait_expired;
  logic entering_mem;

  assign instr_ready = (state == S_IDLE) && !flush;
  assign handshake   = instr_valid && instr_ready;
  assign busy        = (state != S_IDLE);
  assign fsm_state   = state;

  assign is_load_direct  = (op_q == OP_LDR) || (op_q == OP_LDB);
  assign is_store_direct = (op_q == OP_STR) || (op_q == OP_STB);
  assign is_indirect     = (op_q == OP_LDI) || (op_q == OP_STI);
  assign is_illegal      = (op_q == OP_RTI) || (is_indirect && !ENABLE_INDIRECT);

  assign mem_active   = (state == S_MEM1) || (state == S_MEM2);
  // A response in the last allowed cycle wins over the timeout.
  assign wait_expired = mem_active && !mem_resp && (wait_cnt == WAIT_LAST);
  assign entering_mem = ((next_state == S_MEM1) && (state != S_MEM1)) ||
                        ((next_state == S_MEM2) && (state != S_MEM2));

  // Next-state logic; flush overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (handshake) next_state = S_EXEC;
      end
      S_EXEC: begin
        if (is_illegal) begin
          next_state = S_IDLE;
        end else if (is_load_direct || is_store_direct || is_indirect ||
                     (op_q == OP_TRAP)) begin
          next_state = S_MEM1;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_MEM1: begin
        if (mem_resp) begin
          if (is_load_direct)   next_state = S_WB;
          else if (is_indirect) next_state = S_MEM2;
          else                  next_state = S_IDLE;
        end else if (wait_expired) begin
          next_state = S_IDLE;
        end
      end
      S_MEM2: begin
        if (mem_resp) begin
          if (op_q == OP_LDI) next_state = S_WB;
          else                next_state = S_IDLE;
        end else if (wait_expired) begin
          next_state = S_IDLE;
        end
      end
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 8'd0;
      op_q       <= 4'd0;
      imm_q      <= 1'b0;
      shf_q      <= 1'b0;
      jsr_q      <= 1'b0;
      illegal_op <= 1'b0;
      mem_error  <= 1'b0;
    end else begin
      state <= next_state;
      if (handshake) begin
        op_q  <= opcode;
        imm_q <= imm_bit;
        shf_q <= shf_dir;
        jsr_q <= jsr_bit;
      end
      if (entering_mem) begin
        wait_cnt <= 8'd0;
      end else if (mem_active && !mem_resp) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // Error pulses are suppressed when the cycle is flushed.
      illegal_op <= (state == S_EXEC) && is_illegal && !flush;
      mem_error  <= wait_expired && !flush;
    end
  end

  // Control outputs: decoded from state and captured fields, with the
  // response-dependent strobes in MEM1 and the flush gating of load strobes.
  always_comb begin
    aluop             = ALU_ADD;
    sr2mux_sel        = 1'b0;
    addr1mux_sel      = 1'b0;
    addr2mux_sel      = 2'b00;
    memaddrmux_sel    = 1'b0;
    destmux_sel       = 1'b0;
    jsrmux_sel        = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    load_regfile      = 1'b0;
    load_cc           = 1'b0;
    load_pc           = 1'b0;
    load_mar_indirect = 1'b0;

    case (state)
      S_EXEC: begin
        if (!is_illegal) begin
          case (op_q)
            OP_ADD, OP_AND: begin
              aluop        = (op_q == OP_ADD) ? ALU_ADD : ALU_AND;
              sr2mux_sel   = imm_q;
              load_regfile = 1'b1;
              load_cc      = 1'b1;
            end
            OP_NOT: begin
              aluop        = ALU_NOT;
              load_regfile = 1'b1;
              load_cc      = 1'b1;
            end
            OP_SHF: begin
              if (!shf_q)     aluop = ALU_SLL;
              else if (imm_q) aluop = ALU_SRA;
              else            aluop = ALU_SRL;
              load_regfile = 1'b1;
              load_cc      = 1'b1;
            end
            OP_LEA: begin
              addr2mux_sel = 2'b10;
              load_regfile = 1'b1;
              load_cc      = 1'b1;
            end
            OP_BR: begin
              addr2mux_sel = 2'b10;
              load_pc      = 1'b1;
            end
            OP_JMP: begin
              addr1mux_sel = 1'b1;
              load_pc      = 1'b1;
            end
            OP_JSR: begin
              destmux_sel  = 1'b1;
              jsrmux_sel   = jsr_q;
              load_regfile = 1'b1;
              load_pc      = 1'b1;
            end
            OP_LDR, OP_LDB, OP_STR, OP_STB, OP_LDI, OP_STI: begin
              addr1mux_sel = 1'b1;
              addr2mux_sel = 2'b01;
            end
            OP_TRAP: begin
              destmux_sel  = 1'b1;
              load_regfile = 1'b1;
            end
            default: aluop = ALU_PASS;
          endcase
        end
      end
      S_MEM1: begin
        mem_read       = is_load_direct || is_indirect || (op_q == OP_TRAP);
        mem_write      = is_store_direct;
        memaddrmux_sel = (op_q == OP_TRAP);
        if (mem_resp) begin
          load_mar_indirect = is_indirect;
          load_pc           = (op_q == OP_TRAP);
        end
      end
      S_MEM2: begin
        mem_read  = (op_q == OP_LDI);
        mem_write = (op_q == OP_STI);
      end
      S_WB: begin
        load_regfile = 1'b1;
        load_cc      = 1'b1;
      end
      default: ;
    endcase

    if (flush) begin
      load_regfile      = 1'b0;
      load_cc           = 1'b0;
      load_pc           = 1'b0;
      load_mar_indirect = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3b_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lc3b_ctrl_sequencer
//
// Directed testbench. Main instance: MAX_MEM_WAIT=4, ENABLE_INDIRECT=1.
// Second instance (n_*): default MAX_MEM_WAIT, ENABLE_INDIRECT=0, with its
// own instr_valid so it only ever sees the instruction meant for it.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit later.
// ---------------------------------------------------------------------------
module tb_lc3b_ctrl_sequencer;

  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_JSR = 4'b0100,
                         OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010,
                         OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_SHF = 4'b1101,
                         OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       n_instr_valid = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       imm_bit = 1'b0, shf_dir = 1'b0, jsr_bit = 1'b0;
  logic       flush = 1'b0, mem_resp = 1'b0;

  logic       instr_ready, busy, illegal_op, mem_error;
  logic [2:0] aluop, fsm_state;
  logic       sr2mux_sel, addr1mux_sel, memaddrmux_sel, destmux_sel, jsrmux_sel;
  logic [1:0] addr2mux_sel;
  logic       mem_read, mem_write, load_regfile, load_cc, load_pc, load_mar_indirect;

  logic       n_instr_ready, n_busy, n_illegal_op, n_mem_error;
  logic [2:0] n_aluop, n_fsm_state;
  logic       n_sr2mux_sel, n_addr1mux_sel, n_memaddrmux_sel, n_destmux_sel, n_jsrmux_sel;
  logic [1:0] n_addr2mux_sel;
  logic       n_mem_read, n_mem_write, n_load_regfile, n_load_cc, n_load_pc, n_load_mar_indirect;

  int checks = 0;
  int errors = 0;

  // Control bundle order:
  // {aluop[2:0], sr2, addr1, addr2[1:0], memaddr, dest, jsrmux,
  //  mem_read, mem_write, load_regfile, load_cc, load_pc, load_mar_indirect}
  logic [15:0] ctl, n_ctl;
  assign ctl = {aluop, sr2mux_sel, addr1mux_sel, addr2mux_sel, memaddrmux_sel,
                destmux_sel, jsrmux_sel, mem_read, mem_write, load_regfile,
                load_cc, load_pc, load_mar_indirect};
  assign n_ctl = {n_aluop, n_sr2mux_sel, n_addr1mux_sel, n_addr2mux_sel, n_memaddrmux_sel,
                  n_destmux_sel, n_jsrmux_sel, n_mem_read, n_mem_write, n_load_regfile,
                  n_load_cc, n_load_pc, n_load_mar_indirect};

  function automatic logic [15:0] exp_ctl(input logic [2:0] alu, input logic sr2, a1,
                                          input logic [1:0] a2, input logic ma, dm, jm,
                                          mr, mw, lr, lc, lp, lmi);
    return {alu, sr2, a1, a2, ma, dm, jm, mr, mw, lr, lc, lp, lmi};
  endfunction

  lc3b_ctrl_sequencer #(.MAX_MEM_WAIT(4), .ENABLE_INDIRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .imm_bit(imm_bit), .shf_dir(shf_dir), .jsr_bit(jsr_bit),
    .flush(flush), .mem_resp(mem_resp), .aluop(aluop), .sr2mux_sel(sr2mux_sel),
    .addr1mux_sel(addr1mux_sel), .memaddrmux_sel(memaddrmux_sel),
    .destmux_sel(destmux_sel), .jsrmux_sel(jsrmux_sel), .addr2mux_sel(addr2mux_sel),
    .mem_read(mem_read), .mem_write(mem_write), .load_regfile(load_regfile),
    .load_cc(load_cc), .load_pc(load_pc), .load_mar_indirect(load_mar_indirect),
    .busy(busy), .illegal_op(illegal_op), .mem_error(mem_error), .fsm_state(fsm_state)
  );

  lc3b_ctrl_sequencer #(.MAX_MEM_WAIT(15), .ENABLE_INDIRECT(1'b0)) dut_ni (
    .clk(clk), .rst(rst), .instr_valid(n_instr_valid), .instr_ready(n_instr_ready),
    .opcode(opcode), .imm_bit(imm_bit), .shf_dir(shf_dir), .jsr_bit(jsr_bit),
    .flush(flush), .mem_resp(mem_resp), .aluop(n_aluop), .sr2mux_sel(n_sr2mux_sel),
    .addr1mux_sel(n_addr1mux_sel), .memaddrmux_sel(n_memaddrmux_sel),
    .destmux_sel(n_destmux_sel), .jsrmux_sel(n_jsrmux_sel), .addr2mux_sel(n_addr2mux_sel),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .load_regfile(n_load_regfile),
    .load_cc(n_load_cc), .load_pc(n_load_pc), .load_mar_indirect(n_load_mar_indirect),
    .busy(n_busy), .illegal_op(n_illegal_op), .mem_error(n_mem_error), .fsm_state(n_fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one handshake (caller ensures IDLE), leave the bench settled in EXEC.
  task automatic issue(input logic [3:0] op, input logic imm, dir, jsr);
    opcode = op; imm_bit = imm; shf_dir = dir; jsr_bit = jsr;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (ctl !== 16'h0) begin errors++; $display("FAIL reset_ctl: got %h expected %h", ctl, 16'h0); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({illegal_op, mem_error} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {illegal_op, mem_error}); end
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    checks++; if (n_instr_ready !== 1'b1) begin errors++; $display("FAIL reset_n_ready: got %b expected 1", n_instr_ready); end
  endtask

  task automatic test_add;
    opcode = OP_ADD; imm_bit = 1'b1; shf_dir = 1'b0; jsr_bit = 1'b0;
    instr_valid = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready_c0: got %b expected 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    #1;
    checks++; if (ctl !== exp_ctl(3'd0,1,0,2'b00,0,0,0,0,0,1,1,0,0)) begin errors++; $display("FAIL add_exec: got %h expected %h", ctl, exp_ctl(3'd0,1,0,2'b00,0,0,0,0,0,1,1,0,0)); end
    checks++; if ({busy, instr_ready} !== 2'b10) begin errors++; $display("FAIL add_busy_c1: got %b expected 10", {busy, instr_ready}); end
    tick();
    checks++; if ({busy, instr_ready} !== 2'b01) begin errors++; $display("FAIL add_idle_c2: got %b expected 01", {busy, instr_ready}); end
  endtask

  task automatic test_alu_ops;
    // op, imm, dir, expected aluop, expected sr2mux_sel
    logic [3:0] op_t  [5] = '{OP_AND, OP_NOT, OP_SHF, OP_SHF, OP_SHF};
    logic       imm_t [5] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1};
    logic       dir_t [5] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
    logic [2:0] alu_t [5] = '{3'd1,   3'd2,   3'd4,   3'd5,   3'd6};
    logic       sr2_t [5] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(op_t[i], imm_t[i], dir_t[i], 1'b0);
      checks++;
      if (ctl !== exp_ctl(alu_t[i], sr2_t[i],0,2'b00,0,0,0,0,0,1,1,0,0)) begin
        errors++; $display("FAIL alu_op_%0d: got %h expected %h", i, ctl, exp_ctl(alu_t[i], sr2_t[i],0,2'b00,0,0,0,0,0,1,1,0,0));
      end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_idle_%0d: got busy %b expected 0", i, busy); end
    end
  endtask

  task automatic test_control_flow;
    logic [3:0]  op_t  [5] = '{OP_LEA, OP_BR, OP_JMP, OP_JSR, OP_JSR};
    logic        jsr_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_t [5];
    exp_t[0] = exp_ctl(3'd0,0,0,2'b10,0,0,0,0,0,1,1,0,0);
    exp_t[1] = exp_ctl(3'd0,0,0,2'b10,0,0,0,0,0,0,0,1,0);
    exp_t[2] = exp_ctl(3'd0,0,1,2'b00,0,0,0,0,0,0,0,1,0);
    exp_t[3] = exp_ctl(3'd0,0,0,2'b00,0,1,1,0,0,1,0,1,0);
    exp_t[4] = exp_ctl(3'd0,0,0,2'b00,0,1,0,0,0,1,0,1,0);
    for (int i = 0; i < 5; i++) begin
      issue(op_t[i], 1'b0, 1'b0, jsr_t[i]);
      checks++; if (ctl !== exp_t[i]) begin errors++; $display("FAIL flow_%0d: got %h expected %h", i, ctl, exp_t[i]); end
      tick();
      checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL flow_idle_%0d: got %0d expected 0", i, fsm_state); end
    end
  endtask

  task automatic test_ldr;
    int busy_cnt = 0, rd_cnt = 0;
    issue(OP_LDR, 1'b0, 1'b0, 1'b0);
    busy_cnt += int'(busy);
    checks++; if (ctl !== exp_ctl(3'd0,0,1,2'b01,0,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL ldr_exec: got %h expected %h", ctl, exp_ctl(3'd0,0,1,2'b01,0,0,0,0,0,0,0,0,0)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_resp = (i == 2);
      #1;
      busy_cnt += int'(busy);
      rd_cnt += int'(mem_read);
      checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)) begin errors++; $display("FAIL ldr_mem1_%0d: got %h expected %h", i, ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)); end
    end
    tick();
    mem_resp = 1'b0;
    #1;
    busy_cnt += int'(busy);
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,0,0,1,1,0,0)) begin errors++; $display("FAIL ldr_wb: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,0,0,1,1,0,0)); end
    tick();
    busy_cnt += int'(busy);
    checks++; if ({busy, ctl} !== 17'h0) begin errors++; $display("FAIL ldr_done: got %h expected 0", {busy, ctl}); end
    // EXEC + three MEM1 cycles + WB
    checks++; if (busy_cnt != 5) begin errors++; $display("FAIL ldr_busy_cycles: got %0d expected 5", busy_cnt); end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL ldr_read_cycles: got %0d expected 3", rd_cnt); end
  endtask

  task automatic test_ldi_sti;
    issue(OP_LDI, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== exp_ctl(3'd0,0,1,2'b01,0,0,0,0,0,0,0,0,0)) begin errors++; $display("FAIL ldi_exec: got %h expected %h", ctl, exp_ctl(3'd0,0,1,2'b01,0,0,0,0,0,0,0,0,0)); end
    tick(); mem_resp = 1'b1; #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,1)) begin errors++; $display("FAIL ldi_mem1: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,1)); end
    tick(); mem_resp = 1'b0; #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)) begin errors++; $display("FAIL ldi_mem2_a: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)); end
    tick(); mem_resp = 1'b1; #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)) begin errors++; $display("FAIL ldi_mem2_b: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,0)); end
    tick(); mem_resp = 1'b0; #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,0,0,1,1,0,0)) begin errors++; $display("FAIL ldi_wb: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,0,0,1,1,0,0)); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ldi_done: got busy %b expected 0", busy); end
    // STI: read pointer in MEM1, write in MEM2, no writeback
    issue(OP_STI, 1'b0, 1'b0, 1'b0);
    tick(); mem_resp = 1'b1; #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,1)) begin errors++; $display("FAIL sti_mem1: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,1,0,0,0,0,1)); end
    tick(); #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,0,0,0,1,0,0,0,0)) begin errors++; $display("FAIL sti_mem2: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,0,0,0,1,0,0,0,0)); end
    tick(); mem_resp = 1'b0; #1;
    checks++; if ({busy, ctl} !== 17'h0) begin errors++; $display("FAIL sti_done: got %h expected 0", {busy, ctl}); end
  endtask

  task automatic test_illegal;
    // LDI on the instance built without indirect support
    opcode = OP_LDI; imm_bit = 1'b0; shf_dir = 1'b0; jsr_bit = 1'b0;
    n_instr_valid = 1'b1;
    tick();
    n_instr_valid = 1'b0;
    #1;
    checks++; if ({n_busy, n_ctl} !== {1'b1, 16'h0}) begin errors++; $display("FAIL ni_exec: got %h expected %h", {n_busy, n_ctl}, {1'b1, 16'h0}); end
    tick();
    checks++; if ({n_illegal_op, n_busy, n_mem_read} !== 3'b100) begin errors++; $display("FAIL ni_pulse: got %b expected 100", {n_illegal_op, n_busy, n_mem_read}); end
    tick();
    checks++; if ({n_illegal_op, n_mem_read} !== 2'b00) begin errors++; $display("FAIL ni_after: got %b expected 00", {n_illegal_op, n_mem_read}); end
    // RTI on the main instance
    issue(OP_RTI, 1'b0, 1'b0, 1'b0);
    checks++; if ({illegal_op, ctl} !== 17'h0) begin errors++; $display("FAIL rti_exec: got %h expected 0", {illegal_op, ctl}); end
    tick();
    checks++; if ({illegal_op, busy} !== 2'b10) begin errors++; $display("FAIL rti_pulse: got %b expected 10", {illegal_op, busy}); end
    tick();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL rti_clear: got %b expected 0", illegal_op); end
    // RTI flushed in EXEC raises no pulse
    issue(OP_RTI, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if ({illegal_op, busy} !== 2'b00) begin errors++; $display("FAIL rti_flush: got %b expected 00", {illegal_op, busy}); end
  endtask

  task automatic test_timeout;
    issue(OP_STR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++; if ({mem_error, ctl} !== {1'b0, exp_ctl(3'd0,0,0,2'b00,0,0,0,0,1,0,0,0,0)}) begin errors++; $display("FAIL to_mem1_%0d: got %h expected %h", i, {mem_error, ctl}, {1'b0, exp_ctl(3'd0,0,0,2'b00,0,0,0,0,1,0,0,0,0)}); end
    end
    tick();
    checks++; if ({mem_error, busy, ctl} !== {2'b10, 16'h0}) begin errors++; $display("FAIL to_abort: got %h expected %h", {mem_error, busy, ctl}, {2'b10, 16'h0}); end
    tick();
    checks++; if ({mem_error, load_regfile} !== 2'b00) begin errors++; $display("FAIL to_clear: got %b expected 00", {mem_error, load_regfile}); end
    // Response in the last allowed cycle wins
    issue(OP_STR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_resp = (i == 3);
      #1;
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL late_mem1_%0d: got %b expected 1", i, mem_write); end
    end
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if ({mem_error, busy, mem_write} !== 3'b000) begin errors++; $display("FAIL late_done: got %b expected 000", {mem_error, busy, mem_write}); end
    tick();
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL late_noerr: got %b expected 0", mem_error); end
  endtask

  task automatic test_trap_flush;
    issue(OP_TRAP, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,0,1,0,0,0,1,0,0,0)) begin errors++; $display("FAIL trap_exec: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,0,1,0,0,0,1,0,0,0)); end
    tick();
    mem_resp = 1'b1; flush = 1'b1;
    #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,1,0,0,1,0,0,0,0,0)) begin errors++; $display("FAIL trap_flush_mem1: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,1,0,0,1,0,0,0,0,0)); end
    tick();
    mem_resp = 1'b0; flush = 1'b0;
    #1;
    checks++; if ({busy, instr_ready, mem_error} !== 3'b010) begin errors++; $display("FAIL trap_flush_idle: got %b expected 010", {busy, instr_ready, mem_error}); end
    // Unflushed TRAP loads PC on the response
    issue(OP_TRAP, 1'b0, 1'b0, 1'b0);
    tick();
    mem_resp = 1'b1;
    #1;
    checks++; if (ctl !== exp_ctl(3'd0,0,0,2'b00,1,0,0,1,0,0,0,1,0)) begin errors++; $display("FAIL trap_resp: got %h expected %h", ctl, exp_ctl(3'd0,0,0,2'b00,1,0,0,1,0,0,0,1,0)); end
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trap_done: got busy %b expected 0", busy); end
    // Flush in IDLE blocks the handshake
    opcode = OP_ADD; instr_valid = 1'b1; flush = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL idle_flush_ready: got %b expected 0", instr_ready); end
    tick();
    instr_valid = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_stay: got busy %b expected 0", busy); end
    // mem_resp in IDLE is ignored
    mem_resp = 1'b1;
    #1;
    checks++; if (ctl !== 16'h0) begin errors++; $display("FAIL idle_resp: got %h expected 0", ctl); end
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_resp_stay: got busy %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    issue(OP_ADD, 1'b0, 1'b0, 1'b0);
    opcode = OP_NOT; instr_valid = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_exec_ready: got %b expected 0", instr_ready); end
    tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", instr_ready); end
    tick();
    instr_valid = 1'b0;
    #1;
    checks++; if (ctl !== exp_ctl(3'd2,0,0,2'b00,0,0,0,0,0,1,1,0,0)) begin errors++; $display("FAIL b2b_not: got %h expected %h", ctl, exp_ctl(3'd2,0,0,2'b00,0,0,0,0,0,1,1,0,0)); end
    tick();
  endtask

  task automatic test_reset_mid_mem;
    issue(OP_LDR, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmm_mem1: got %b expected 1", mem_read); end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    checks++; if ({busy, instr_ready, illegal_op, mem_error, ctl} !== {4'b0100, 16'h0}) begin errors++; $display("FAIL rmm_after: got %h expected %h", {busy, instr_ready, illegal_op, mem_error, ctl}, {4'b0100, 16'h0}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_control_flow();
    test_ldr();
    test_ldi_sti();
    test_illegal();
    test_timeout();
    test_trap_flush();
    test_back_to_back();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
